vga_fb_scanout: RTL

// Display-side reader of the dual-port framebuffer RAM. Generates 640x480@60 VGA timing,

---
 rtl/vga_fb_scanout.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/vga_fb_scanout.sv
// 640x480@60 VGA scanout from the display port of the cell framebuffer RAM.
// Optional SCANOUT_FRAME_IRQ_EN adds a one-rawclk frame_irq pulse at the start of vblank.
module vga_fb_scanout #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int PIX_DIV    = 4,
    parameter int CELL_LOG2  = 5,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33
) (
    input  logic                  rawclk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] disp_addr,
    input  logic [DATA_WIDTH-1:0] disp_color,
    output logic                  vga_hs,
    output logic                  vga_vs,
    output logic [3:0]            vga_r,
    output logic [3:0]            vga_g,
    output logic [3:0]            vga_b
`ifdef SCANOUT_FRAME_IRQ_EN
    ,
    output logic                  frame_irq
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);
    localparam int DW      = $clog2(PIX_DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [31:0]   CELLS_X  = 32'(H_ACTIVE >> CELL_LOG2);

    logic [DW-1:0]         div_q, div_d;
    logic [HW-1:0]         hcnt_q, hcnt_d;
    logic [VW-1:0]         vcnt_q, vcnt_d;
    logic                  pix_ce;
    logic                  h_last;

    // Stage 1: address/sync derived from the counters; stage 2: pins.
    logic [ADDR_WIDTH-1:0] disp_addr_q, disp_addr_d;
    logic                  active1_q, active1_d;
    logic                  hs1_q, hs1_d;
    logic                  vs1_q, vs1_d;
    logic                  hs_q, vs_q;
    logic [11:0]           rgb_q, rgb_d;

    logic                  unused_color_bits;
    assign unused_color_bits = ^disp_color[DATA_WIDTH-1:12];

    always_comb begin
        pix_ce = (div_q == DIV_LAST);
        div_d  = pix_ce ? '0 : div_q + 1'b1;
        h_last = (hcnt_q == H_LAST);
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (pix_ce) begin
            if (h_last) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        active1_d   = (hcnt_q < H_ACT_C) && (vcnt_q < V_ACT_C);
        disp_addr_d = '0;
        if (active1_d) begin
            disp_addr_d = ADDR_WIDTH'((32'(vcnt_q) >> CELL_LOG2) * CELLS_X
                                      + (32'(hcnt_q) >> CELL_LOG2));
        end
        hs1_d = !((hcnt_q >= HS_START) && (hcnt_q < HS_END));
        vs1_d = !((vcnt_q >= VS_START) && (vcnt_q < VS_END));
        // RAM data has had at least one rawclk to settle since the address moved.
        rgb_d = active1_q ? disp_color[11:0] : 12'h000;
    end

    always_ff @(posedge rawclk or posedge rst) begin
        if (rst) begin
            div_q       <= '0;
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            disp_addr_q <= '0;
            active1_q   <= 1'b0;
            hs1_q       <= 1'b1;
            vs1_q       <= 1'b1;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            rgb_q       <= '0;
        end else begin
            div_q  <= div_d;
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            if (pix_ce) begin
                disp_addr_q <= disp_addr_d;
                active1_q   <= active1_d;
                hs1_q       <= hs1_d;
                vs1_q       <= vs1_d;
                hs_q        <= hs1_q;
                vs_q        <= vs1_q;
                rgb_q       <= rgb_d;
            end
        end
    end

    assign disp_addr = disp_addr_q;
    assign vga_hs    = hs_q;
    assign vga_vs    = vs_q;
    assign vga_r     = rgb_q[11:8];
    assign vga_g     = rgb_q[7:4];
    assign vga_b     = rgb_q[3:0];

`ifdef SCANOUT_FRAME_IRQ_EN
    localparam logic [VW-1:0] V_IRQ = VW'(V_ACTIVE - 1);
    logic frame_irq_q, frame_irq_d;

    // Fires on the tick that moves the scan from the last active line into vblank.
    assign frame_irq_d = pix_ce && h_last && (vcnt_q == V_IRQ);

    always_ff @(posedge rawclk or posedge rst) begin
        if (rst) begin
            frame_irq_q <= 1'b0;
        end else begin
            frame_irq_q <= frame_irq_d;
        end
    end

    assign frame_irq = frame_irq_q;
`endif

endmodule
